link_master_burst: RTL and testbench

Parametrised burst master for the 4-phase req/ack link. Accepts a burst command (start plus length), pulls each word from an upstream valid/ready source and transfers it over the req/ack handshake. Signals completion with done, or, when the watchdog is compiled in, aborts with err if the slave stalls. Sits between a local word producer and the link wire bundle; the peer is the existing link slave.

---
 rtl/link_master_burst.sv | 166 ++++++++++++++++
 tb/tb_link_master_burst.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_master_burst.sv
// rtl/link_master_burst.sv - burst master for the 4-phase req/ack link
//
// Pulls len_i+1 words from an upstream valid/ready source and sends each one
// over the 4-phase req/ack handshake, pulsing done_o when the burst is finished.
// Optional watchdog: define LINK_TIMEOUT_EN to abort a stalled handshake
// phase after TIMEOUT cycles, pulsing err_o.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   start_i     burst request, sampled only while idle
//   len_i       burst length minus one, captured with start_i
//   in_data_i   upstream word
//   in_valid_i  upstream word valid
//   in_ready_o  upstream word accepted this cycle
//   req_o       link request
//   ack_i       link acknowledge from the slave
//   data_o      link data, zero outside the req/ack phases
//   busy_o      burst in progress
//   done_o      one-cycle pulse: burst completed
//   err_o       one-cycle pulse: burst aborted by the watchdog
//   word_cnt_o  index of the word currently in transfer

module link_master_burst #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              req_o,
  input  logic              ack_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  word_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT_LOW,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                timeout_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("link_master_burst: TIMEOUT must be at least 1");
  end

`ifdef LINK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [WD_W-1:0] wdog_inc;
  logic            in_phase;

  // The count includes the current cycle, so the state exits after exactly
  // TIMEOUT cycles in a stalled phase.
  assign in_phase    = (state_q == S_REQ) || (state_q == S_WAIT_LOW);
  assign wdog_inc    = wdog_q + 1'b1;
  assign timeout_hit = in_phase && (wdog_inc == WD_W'(TIMEOUT));

  // Any state change clears the counter, which covers entry to REQ and to
  // WAIT_LOW; outside the handshake phases it simply rests at zero.
  always_comb begin
    wdog_d = '0;
    if (state_d == state_q && in_phase) begin
      wdog_d = wdog_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign err_o = (state_q == S_ERR);
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    data_d     = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d      = len_i;
          word_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (in_valid_i) begin
          data_d  = in_data_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // The exit condition takes priority over a coincident timeout.
        if (ack_i) begin
          state_d = S_WAIT_LOW;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_LOW: begin
        if (!ack_i) begin
          if (word_cnt_q == len_q) begin
            state_d = S_DONE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      data_q     <= data_d;
    end
  end

  assign in_ready_o = (state_q == S_FETCH);
  assign req_o      = (state_q == S_REQ);
  assign data_o     = (state_q == S_REQ || state_q == S_WAIT_LOW) ? data_q : '0;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_link_master_burst.sv
// tb/tb_link_master_burst.sv - directed bench for link_master_burst

module tb_link_master_burst;

  localparam int DATA_W  = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              ack = 1'b0;
  logic              in_ready_o, req_o, busy_o, done_o, err_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  word_cnt_o;

  link_master_burst #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .req_o(req_o), .ack_i(ack), .data_o(data_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // observation counters, written by the monitor, cleared by the tests
  int req_rises, req_cycles, hs, done_n, err_n;
  logic [DATA_W-1:0] link_q[$];
  logic [LEN_W-1:0]  cnt_q[$];
  logic req_prev = 1'b0;
  logic hs_pending = 1'b0;

  // upstream source and slave model controls
  logic [DATA_W-1:0] src[16];
  int src_idx = 0;
  logic slave_en = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (req_o && !req_prev) begin
        req_rises++;
        link_q.push_back(data_o);
        cnt_q.push_back(word_cnt_o);
      end
      req_prev = req_o;
      if (req_o) req_cycles++;
      hs_pending = in_ready_o && in_valid;
      if (hs_pending) hs++;
      if (done_o) done_n++;
      if (err_o) err_n++;
    end
  end

  // source advances after each accepted word
  initial begin
    forever begin
      @(posedge clk);
      if (hs_pending) src_idx++;
      #3;
      in_data = src[src_idx % 16];
    end
  end

  // slave: ack follows req one cycle later
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ack = slave_en ? req_o : 1'b0;
    end
  end

  task automatic clear_mon();
    req_rises = 0; req_cycles = 0; hs = 0; done_n = 0; err_n = 0;
    link_q.delete(); cnt_q.delete();
    src_idx = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", req_o); end
    n_checks++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if ({done_o, err_o} !== 2'b00) begin n_err++; $display("FAIL reset_done_err: got %b want 00", {done_o, err_o}); end
    n_checks++; if (word_cnt_o !== 4'd0) begin n_err++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst4();
    bit seen;
    src[0] = 8'hA0; src[1] = 8'hA1; src[2] = 8'hA2; src[3] = 8'hA3;
    clear_mon();
    in_valid = 1'b1;
    pulse_start(4'd3);
    n_checks++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL b4_fetch_after_start: in_ready %b want 1", in_ready_o); end
    tick();
    n_checks++; if (req_o !== 1'b1) begin n_err++; $display("FAIL b4_req_latency: req %b want 1", req_o); end
    wait_done(100, seen);
    n_checks++; if (!seen) begin n_err++; $display("FAIL b4_done_timeout: done %b want 1", seen); end
    tick();
    n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL b4_busy_after: got %b want 0", busy_o); end
    n_checks++; if (link_q.size() !== 4) begin n_err++; $display("FAIL b4_words: got %0d want 4", link_q.size()); end
    for (int i = 0; i < 4 && i < link_q.size(); i++) begin
      n_checks++; if (link_q[i] !== src[i]) begin n_err++; $display("FAIL b4_data[%0d]: got %h want %h", i, link_q[i], src[i]); end
      n_checks++; if (cnt_q[i] !== LEN_W'(i)) begin n_err++; $display("FAIL b4_cnt[%0d]: got %0d want %0d", i, cnt_q[i], i); end
    end
    n_checks++; if (done_n !== 1) begin n_err++; $display("FAIL b4_done_pulses: got %0d want 1", done_n); end
    n_checks++; if (hs !== 4) begin n_err++; $display("FAIL b4_handshakes: got %0d want 4", hs); end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    bit seen;
    src[0] = 8'h5C; src[1] = 8'hEE;
    clear_mon();
    in_valid = 1'b1;
    pulse_start(4'd0);
    wait_done(50, seen);
    n_checks++; if (!seen) begin n_err++; $display("FAIL single_done_timeout: done %b want 1", seen); end
    repeat (5) tick();
    n_checks++; if (req_rises !== 1) begin n_err++; $display("FAIL single_req_pulses: got %0d want 1", req_rises); end
    n_checks++; if (link_q.size() < 1 || link_q[0] !== 8'h5C) begin n_err++; $display("FAIL single_data: got %h want 5c", link_q.size() ? link_q[0] : 8'hxx); end
    n_checks++; if (hs !== 1) begin n_err++; $display("FAIL single_consumed: got %0d want 1", hs); end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    bit seen;
    bit hit;
    src[0] = 8'hB0; src[1] = 8'hB1; src[2] = 8'hB2;
    clear_mon();
    in_valid = 1'b1;
    pulse_start(4'd2);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (word_cnt_o == 4'd1 && in_ready_o) begin hit = 1'b1; break; end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (!hit) begin n_err++; $display("FAIL stall_reach_fetch1: reached %b want 1", hit); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if ({req_o, in_ready_o} !== 2'b01) begin n_err++; $display("FAIL stall_hold[%0d]: req,in_ready %b want 01", i, {req_o, in_ready_o}); end
    end
    in_valid = 1'b1;
    wait_done(100, seen);
    n_checks++; if (!seen) begin n_err++; $display("FAIL stall_done_timeout: done %b want 1", seen); end
    tick();
    n_checks++; if (link_q.size() !== 3) begin n_err++; $display("FAIL stall_words: got %0d want 3", link_q.size()); end
    for (int i = 0; i < 3 && i < link_q.size(); i++) begin
      n_checks++; if (link_q[i] !== src[i]) begin n_err++; $display("FAIL stall_data[%0d]: got %h want %h", i, link_q[i], src[i]); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit seen;
    src[0] = 8'hC0; src[1] = 8'hC1;
    clear_mon();
    in_valid = 1'b1;
    pulse_start(4'd1);
    tick(); tick();
    pulse_start(4'd7);
    wait_done(100, seen);
    n_checks++; if (!seen) begin n_err++; $display("FAIL ign_done_timeout: done %b want 1", seen); end
    repeat (3) tick();
    n_checks++; if (req_rises !== 2) begin n_err++; $display("FAIL ign_words: got %0d want 2", req_rises); end
    n_checks++; if (done_n !== 1) begin n_err++; $display("FAIL ign_done_pulses: got %0d want 1", done_n); end
    n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ign_busy: got %b want 0", busy_o); end
    in_valid = 1'b0;
  endtask

  task automatic test_stuck_ack();
    bit seen;
    src[0] = 8'hD0; src[1] = 8'hD1; src[2] = 8'hD2;
    clear_mon();
    slave_en = 1'b0;
    in_valid = 1'b1;
    pulse_start(4'd0);
`ifdef LINK_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (err_o) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_err++; $display("FAIL to_err_timeout: err %b want 1", seen); end
    tick();
    n_checks++; if (req_cycles !== TIMEOUT) begin n_err++; $display("FAIL to_req_cycles: got %0d want %0d", req_cycles, TIMEOUT); end
    n_checks++; if (err_n !== 1) begin n_err++; $display("FAIL to_err_pulses: got %0d want 1", err_n); end
    n_checks++; if (done_n !== 0) begin n_err++; $display("FAIL to_no_done: got %0d want 0", done_n); end
    n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL to_idle: busy %b want 0", busy_o); end
    in_valid = 1'b0;
    slave_en = 1'b1;
    tick();
    clear_mon();
    in_valid = 1'b1;
    pulse_start(4'd1);
    wait_done(100, seen);
    n_checks++; if (!seen) begin n_err++; $display("FAIL to_restart_done: done %b want 1", seen); end
    tick();
    n_checks++; if (req_rises !== 2) begin n_err++; $display("FAIL to_restart_words: got %0d want 2", req_rises); end
`else
    repeat (40) tick();
    n_checks++; if (req_o !== 1'b1) begin n_err++; $display("FAIL nowd_req_held: got %b want 1", req_o); end
    n_checks++; if (err_n !== 0) begin n_err++; $display("FAIL nowd_err: got %0d want 0", err_n); end
    slave_en = 1'b1;
    wait_done(50, seen);
    n_checks++; if (!seen) begin n_err++; $display("FAIL nowd_done: done %b want 1", seen); end
    tick();
    n_checks++; if (req_rises !== 1) begin n_err++; $display("FAIL nowd_words: got %0d want 1", req_rises); end
`endif
    in_valid = 1'b0;
    slave_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit hit;
    src[0] = 8'hE0; src[1] = 8'hE1; src[2] = 8'hE2; src[3] = 8'hE3;
    clear_mon();
    in_valid = 1'b1;
    pulse_start(4'd3);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (word_cnt_o == 4'd2 && busy_o && !in_ready_o && !req_o && !done_o) begin hit = 1'b1; break; end
      tick();
    end
    n_checks++; if (!hit) begin n_err++; $display("FAIL rm_reach_wait_low: reached %b want 1", hit); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({req_o, in_ready_o, busy_o, done_o, err_o} !== 5'b0) begin n_err++; $display("FAIL rm_outputs: req,rdy,busy,done,err %b want 00000", {req_o, in_ready_o, busy_o, done_o, err_o}); end
    n_checks++; if (data_o !== 8'h00 || word_cnt_o !== 4'd0) begin n_err++; $display("FAIL rm_data_cnt: data %h cnt %0d want 00 0", data_o, word_cnt_o); end
    repeat (3) tick();
    n_checks++; if (done_n !== 0 || err_n !== 0) begin n_err++; $display("FAIL rm_no_pulse: done %0d err %0d want 0 0", done_n, err_n); end
    n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rm_stays_idle: busy %b want 0", busy_o); end
    src[0] = 8'hF0; src[1] = 8'hF1;
    clear_mon();
    pulse_start(4'd1);
    wait_done(100, seen);
    n_checks++; if (!seen) begin n_err++; $display("FAIL rm_restart_done: done %b want 1", seen); end
    tick();
    n_checks++; if (link_q.size() !== 2) begin n_err++; $display("FAIL rm_restart_words: got %0d want 2", link_q.size()); end
    for (int i = 0; i < 2 && i < link_q.size(); i++) begin
      n_checks++; if (link_q[i] !== src[i]) begin n_err++; $display("FAIL rm_restart_data[%0d]: got %h want %h", i, link_q[i], src[i]); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) src[i] = 8'h00;
    test_reset();
    test_burst4();
    test_single();
    test_stall();
    test_start_ignored();
    test_stuck_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
